controle_multiciclo: RTL and testbench

Multi-cycle control FSM that sequences the MIPS32 datapath (PC, IR, register file, ALU, unified memory) over several cycles per instruction. It supports R-type, ADDI, J, JAL, BEQ, BNE, LW and SW. It handshakes with the UART-backed memory through a ready signal, times out on stalled accesses, and lets the UART debugger pause and single-step execution. It replaces the single-cycle decoder in the processor top.

---
 rtl/controle_multiciclo_pkg.sv | 149 ++++++++++++++
 rtl/controle_multiciclo_espera_mem.sv | 27 ++
 rtl/controle_multiciclo.sv | 100 ++++++++++
 tb/tb_controle_multiciclo.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/controle_multiciclo_pkg.sv
// pkg_controle: opcodes, state encoding, datapath select encodings and the
// per-state Moore control word shared by the multi-cycle controller.
package pkg_controle;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [3:0] {
        INICIO       = 4'd0,
        BUSCA        = 4'd1,
        DECODIFICA   = 4'd2,
        EXEC_R       = 4'd3,
        ESCRITA_R    = 4'd4,
        EXEC_I       = 4'd5,
        ESCRITA_I    = 4'd6,
        CALC_END     = 4'd7,
        LER_MEM      = 4'd8,
        ESCRITA_MEM  = 4'd9,
        ESCREVER_MEM = 4'd10,
        DESVIO       = 4'd11,
        SALTO        = 4'd12,
        SALTO_LIGA   = 4'd13,
        PAUSADO      = 4'd14,
        ERRO         = 4'd15
    } estado_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] ULA_B_REG      = 2'b00;
    localparam logic [1:0] ULA_B_QUATRO   = 2'b01;
    localparam logic [1:0] ULA_B_IMM      = 2'b10;
    localparam logic [1:0] ULA_B_IMM_DESL = 2'b11;

    localparam logic [1:0] PC_ULA    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SALTO  = 2'b10;

    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    localparam logic [1:0] DEST_RT = 2'b00;
    localparam logic [1:0] DEST_RD = 2'b01;
    localparam logic [1:0] DEST_RA = 2'b10;

    typedef struct packed {
        logic       pc_escrever;
        logic       mem_ler;
        logic       mem_escrever;
        logic       iord;
        logic [1:0] alu_op;
        logic       fonte_ula_a;
        logic [1:0] fonte_ula_b;
        logic [1:0] fonte_pc;
        logic [1:0] memtoreg;
        logic       escrever_reg;
        logic [1:0] reg_destino;
        logic       erro;
    } sinais_t;

    function automatic estado_t despacho(input logic [5:0] op);
        case (op)
            OP_R:          return EXEC_R;
            OP_ADDI:       return EXEC_I;
            OP_LW, OP_SW:  return CALC_END;
            OP_BEQ, OP_BNE: return DESVIO;
            OP_J:          return SALTO;
            OP_JAL:        return SALTO_LIGA;
            default:       return ERRO;
        endcase
    endfunction

    // Only the state-dependent part; mem_pronta/zero gating is added in the top.
    function automatic sinais_t sinais_moore(input estado_t e);
        sinais_t s;
        s = '0;
        case (e)
            BUSCA: begin
                s.mem_ler     = 1'b1;
                s.fonte_ula_b = ULA_B_QUATRO;
                s.alu_op      = ALU_ADD;
                s.fonte_pc    = PC_ULA;
            end
            DECODIFICA: s.fonte_ula_b = ULA_B_IMM_DESL;
            EXEC_R: begin
                s.fonte_ula_a = 1'b1;
                s.fonte_ula_b = ULA_B_REG;
                s.alu_op      = ALU_FUNCT;
            end
            ESCRITA_R: begin
                s.escrever_reg = 1'b1;
                s.reg_destino  = DEST_RD;
                s.memtoreg     = MTR_ALUOUT;
            end
            EXEC_I, CALC_END: begin
                s.fonte_ula_a = 1'b1;
                s.fonte_ula_b = ULA_B_IMM;
                s.alu_op      = ALU_ADD;
            end
            ESCRITA_I: begin
                s.escrever_reg = 1'b1;
                s.reg_destino  = DEST_RT;
                s.memtoreg     = MTR_ALUOUT;
            end
            LER_MEM: begin
                s.mem_ler = 1'b1;
                s.iord    = 1'b1;
            end
            ESCRITA_MEM: begin
                s.escrever_reg = 1'b1;
                s.reg_destino  = DEST_RT;
                s.memtoreg     = MTR_MDR;
            end
            ESCREVER_MEM: begin
                s.mem_escrever = 1'b1;
                s.iord         = 1'b1;
            end
            DESVIO: begin
                s.fonte_ula_a = 1'b1;
                s.fonte_ula_b = ULA_B_REG;
                s.alu_op      = ALU_SUB;
                s.fonte_pc    = PC_ALUOUT;
            end
            SALTO: begin
                s.pc_escrever = 1'b1;
                s.fonte_pc    = PC_SALTO;
            end
            SALTO_LIGA: begin
                s.pc_escrever  = 1'b1;
                s.fonte_pc     = PC_SALTO;
                s.escrever_reg = 1'b1;
                s.reg_destino  = DEST_RA;
                s.memtoreg     = MTR_PC;
            end
            ERRO: s.erro = 1'b1;
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controle_multiciclo_espera_mem.sv
// controle_espera_mem: counts cycles spent waiting on mem_pronta and flags
// expiry on the cycle the count would reach TIMEOUT_MEM (0 disables it).
module controle_espera_mem #(
    parameter int TIMEOUT_MEM = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic limpar,
    input  logic incrementar,
    output logic expirou
);
    localparam int W = TIMEOUT_MEM > 1 ? $clog2(TIMEOUT_MEM + 1) : 1;

    logic [W-1:0] cont;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cont <= '0;
        else if (limpar)
            cont <= '0;
        else if (incrementar)
            cont <= cont + W'(1);
    end

    assign expirou = (TIMEOUT_MEM != 0) && incrementar && (cont == W'(TIMEOUT_MEM - 1));

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle MIPS32 control FSM with memory handshake,
// wait timeout and debugger pause/single-step.
module controle_multiciclo
    import pkg_controle::*;
#(
    parameter int TIMEOUT_MEM = 255,
    parameter int LARG_CONT   = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [5:0]           opcode,
    input  logic                 zero,
    input  logic                 mem_pronta,
    input  logic                 pausa,
    input  logic                 passo,
    output logic                 pc_escrever,
    output logic                 ir_escrever,
    output logic                 mem_ler,
    output logic                 mem_escrever,
    output logic                 iord,
    output logic [1:0]           c_ALUOp,
    output logic                 fonte_ula_a,
    output logic [1:0]           fonte_ula_b,
    output logic [1:0]           fonte_pc,
    output logic [1:0]           c_memtoreg,
    output logic                 c_escrever_reg,
    output logic [1:0]           c_reg_destino,
    output logic [3:0]           estado,
    output logic                 erro,
    output logic [LARG_CONT-1:0] instr_cont
);
    estado_t atual, prox;
    sinais_t ctl;
    logic    fim, esperando, expirou;

    assign esperando = (atual == BUSCA || atual == LER_MEM || atual == ESCREVER_MEM) && !mem_pronta;

    controle_espera_mem #(.TIMEOUT_MEM(TIMEOUT_MEM)) u_espera (
        .clock       (clock),
        .reset_n     (reset_n),
        .limpar      (prox != atual),
        .incrementar (esperando),
        .expirou     (expirou)
    );

    always_comb begin
        prox = atual;
        fim  = 1'b0;
        case (atual)
            INICIO:       prox = pausa ? PAUSADO : BUSCA;
            BUSCA:        prox = mem_pronta ? DECODIFICA : BUSCA;
            DECODIFICA:   prox = despacho(opcode);
            EXEC_R:       prox = ESCRITA_R;
            EXEC_I:       prox = ESCRITA_I;
            CALC_END:     prox = (opcode == OP_SW) ? ESCREVER_MEM : LER_MEM;
            LER_MEM:      prox = mem_pronta ? ESCRITA_MEM : LER_MEM;
            ESCREVER_MEM: fim  = mem_pronta;
            ESCRITA_R, ESCRITA_I, ESCRITA_MEM, DESVIO, SALTO, SALTO_LIGA: fim = 1'b1;
            PAUSADO:      prox = (passo || !pausa) ? BUSCA : PAUSADO;
            ERRO:         prox = ERRO;
            default:      prox = ERRO;
        endcase
        if (fim)
            prox = pausa ? PAUSADO : BUSCA;
        if (expirou)
            prox = ERRO;
    end

    // ctl is decoded from the next state so it always equals the word for atual.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            atual      <= INICIO;
            ctl        <= '0;
            instr_cont <= '0;
        end else begin
            atual <= prox;
            ctl   <= sinais_moore(prox);
            if (fim)
                instr_cont <= instr_cont + LARG_CONT'(1);
        end
    end

    assign pc_escrever    = ctl.pc_escrever
                          | (atual == BUSCA && mem_pronta)
                          | (atual == DESVIO && (zero ^ opcode[0]));
    assign ir_escrever    = atual == BUSCA && mem_pronta;
    assign mem_ler        = ctl.mem_ler;
    assign mem_escrever   = ctl.mem_escrever;
    assign iord           = ctl.iord;
    assign c_ALUOp        = ctl.alu_op;
    assign fonte_ula_a    = ctl.fonte_ula_a;
    assign fonte_ula_b    = ctl.fonte_ula_b;
    assign fonte_pc       = ctl.fonte_pc;
    assign c_memtoreg     = ctl.memtoreg;
    assign c_escrever_reg = ctl.escrever_reg;
    assign c_reg_destino  = ctl.reg_destino;
    assign estado         = atual;
    assign erro           = ctl.erro;

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: randomized instruction stream against a per-instruction
// reference model; expected per-cycle outputs are queued and checked by a monitor.
module tb_controle_multiciclo;

    localparam int S_INI = 0, S_BUS = 1, S_DEC = 2, S_EXR = 3, S_ESR = 4, S_EXI = 5,
                   S_ESI = 6, S_CAL = 7, S_LER = 8, S_ESM = 9, S_EME = 10, S_DES = 11,
                   S_SAL = 12, S_SLG = 13, S_PAU = 14, S_ERR = 15;

    localparam logic [5:0] T_R = 6'b000000, T_ADDI = 6'b001000, T_J = 6'b000010,
                           T_JAL = 6'b000011, T_BEQ = 6'b000100, T_BNE = 6'b000101,
                           T_LW = 6'b100011, T_SW = 6'b101011, T_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0]  estado;
        logic        pc_escrever;
        logic        ir_escrever;
        logic        mem_ler;
        logic        mem_escrever;
        logic        iord;
        logic [1:0]  aluop;
        logic        fa;
        logic [1:0]  fb;
        logic [1:0]  fpc;
        logic [1:0]  mtr;
        logic        er;
        logic [1:0]  rd;
        logic        erro;
        logic [31:0] cont;
    } obs_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0, mem_pronta = 1'b0, pausa = 1'b0, passo = 1'b0;
    logic        pc_escrever, ir_escrever, mem_ler, mem_escrever, iord, fonte_ula_a;
    logic        c_escrever_reg, erro;
    logic [1:0]  c_ALUOp, fonte_ula_b, fonte_pc, c_memtoreg, c_reg_destino;
    logic [3:0]  estado;
    logic [31:0] instr_cont;

    obs_t        exp_q[$];
    int unsigned cnt = 0;
    int          checks = 0, errors = 0;
    logic [5:0]  ops[8];

    always #5 clock = ~clock;

    controle_multiciclo #(.TIMEOUT_MEM(4), .LARG_CONT(32)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero),
        .mem_pronta(mem_pronta), .pausa(pausa), .passo(passo),
        .pc_escrever(pc_escrever), .ir_escrever(ir_escrever), .mem_ler(mem_ler),
        .mem_escrever(mem_escrever), .iord(iord), .c_ALUOp(c_ALUOp),
        .fonte_ula_a(fonte_ula_a), .fonte_ula_b(fonte_ula_b), .fonte_pc(fonte_pc),
        .c_memtoreg(c_memtoreg), .c_escrever_reg(c_escrever_reg),
        .c_reg_destino(c_reg_destino), .estado(estado), .erro(erro),
        .instr_cont(instr_cont)
    );

    function automatic logic rb();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    // Expected outputs for one cycle in a given state, straight from the control table.
    function automatic obs_t expect_obs(int s, logic mp, logic z, logic [5:0] op, int unsigned c);
        obs_t e;
        e = '0;
        e.estado = 4'(s);
        e.cont = c;
        case (s)
            S_BUS: begin e.mem_ler = 1; e.fb = 2'b01; e.ir_escrever = mp; e.pc_escrever = mp; end
            S_DEC: e.fb = 2'b11;
            S_EXR: begin e.fa = 1; e.aluop = 2'b10; end
            S_ESR: begin e.er = 1; e.rd = 2'b01; end
            S_EXI, S_CAL: begin e.fa = 1; e.fb = 2'b10; end
            S_ESI: e.er = 1;
            S_LER: begin e.mem_ler = 1; e.iord = 1; end
            S_ESM: begin e.er = 1; e.mtr = 2'b01; end
            S_EME: begin e.mem_escrever = 1; e.iord = 1; end
            S_DES: begin e.fa = 1; e.aluop = 2'b01; e.fpc = 2'b01; e.pc_escrever = z ^ op[0]; end
            S_SAL: begin e.pc_escrever = 1; e.fpc = 2'b10; end
            S_SLG: begin e.pc_escrever = 1; e.fpc = 2'b10; e.er = 1; e.rd = 2'b10; e.mtr = 2'b10; end
            S_ERR: e.erro = 1;
            default: ;
        endcase
        return e;
    endfunction

    // One clock cycle: drive inputs, queue what the DUT must show, advance.
    task automatic cyc(input int s, input logic mp, input logic z, input logic [5:0] op,
                       input logic pa, input logic ps);
        mem_pronta = mp; zero = z; opcode = op; pausa = pa; passo = ps;
        exp_q.push_back(expect_obs(s, mp, z, op, cnt));
        @(posedge clock); #1;
    endtask

    task automatic fin(input int s, input logic mp, input logic z, input logic [5:0] op,
                       input logic pa);
        cyc(s, mp, z, op, pa, rb());
        cnt++;
    endtask

    // Whole instruction from BUSCA; ends in BUSCA/PAUSADO, or stops after DECODIFICA if illegal.
    task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm,
                             input logic pa);
        repeat (wf) cyc(S_BUS, 1'b0, rb(), r6(), rb(), rb());
        cyc(S_BUS, 1'b1, rb(), r6(), rb(), rb());
        cyc(S_DEC, rb(), rb(), op, rb(), rb());
        case (op)
            T_R: begin cyc(S_EXR, rb(), rb(), op, rb(), rb()); fin(S_ESR, rb(), rb(), op, pa); end
            T_ADDI: begin cyc(S_EXI, rb(), rb(), op, rb(), rb()); fin(S_ESI, rb(), rb(), op, pa); end
            T_LW: begin
                cyc(S_CAL, rb(), rb(), op, rb(), rb());
                repeat (wm) cyc(S_LER, 1'b0, rb(), op, rb(), rb());
                cyc(S_LER, 1'b1, rb(), op, rb(), rb());
                fin(S_ESM, rb(), rb(), op, pa);
            end
            T_SW: begin
                cyc(S_CAL, rb(), rb(), op, rb(), rb());
                repeat (wm) cyc(S_EME, 1'b0, rb(), op, rb(), rb());
                fin(S_EME, 1'b1, rb(), op, pa);
            end
            T_BEQ, T_BNE: fin(S_DES, rb(), z, op, pa);
            T_J: fin(S_SAL, rb(), rb(), op, pa);
            T_JAL: fin(S_SLG, rb(), rb(), op, pa);
            default: ;
        endcase
    endtask

    task automatic leave_pause();
        repeat ($urandom_range(2)) cyc(S_PAU, rb(), rb(), r6(), 1'b1, 1'b0);
        if (rb()) cyc(S_PAU, rb(), rb(), r6(), rb(), 1'b1);
        else cyc(S_PAU, rb(), rb(), r6(), 1'b0, 1'b0);
    endtask

    // Async assert, two cycles held, release; caller then runs the INICIO cycle.
    task automatic do_reset();
        reset_n = 1'b0;
        cnt = 0;
        cyc(S_INI, rb(), rb(), r6(), rb(), rb());
        cyc(S_INI, rb(), rb(), r6(), rb(), rb());
        reset_n = 1'b1;
    endtask

    initial begin : monitor
        obs_t g, e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '0;
                g.estado = estado; g.pc_escrever = pc_escrever; g.ir_escrever = ir_escrever;
                g.mem_ler = mem_ler; g.mem_escrever = mem_escrever; g.iord = iord;
                g.aluop = c_ALUOp; g.fa = fonte_ula_a; g.fb = fonte_ula_b; g.fpc = fonte_pc;
                g.mtr = c_memtoreg; g.er = c_escrever_reg; g.rd = c_reg_destino;
                g.erro = erro; g.cont = instr_cont;
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL ctl t=%0t estado got=%0d exp=%0d cont got=%0d exp=%0d word got=%h exp=%h",
                             $time, g.estado, e.estado, g.cont, e.cont, g[47:32], e[47:32]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        ops = '{T_R, T_ADDI, T_J, T_JAL, T_BEQ, T_BNE, T_LW, T_SW};
        @(posedge clock); #1;
        do_reset();
        cyc(S_INI, rb(), rb(), r6(), 1'b0, rb());
        run_instr(T_R, 1'b0, 0, 0, 1'b0);
        run_instr(T_LW, 1'b0, 0, 3, 1'b0);
        run_instr(T_BEQ, 1'b1, 0, 0, 1'b0);
        run_instr(T_BNE, 1'b1, 0, 0, 1'b0);
        run_instr(T_BNE, 1'b0, 1, 0, 1'b0);
        run_instr(T_JAL, 1'b0, 0, 0, 1'b0);
        run_instr(T_SW, 1'b0, 3, 3, 1'b0);
        for (int i = 0; i < 150; i++) begin
            logic pa;
            pa = ($urandom_range(3) == 0);
            run_instr(ops[$urandom_range(7)], rb(), $urandom_range(3), $urandom_range(3), pa);
            if (pa) leave_pause();
        end
        // Illegal opcode: sticky error until reset, which also drops a live memory request.
        run_instr(T_BAD, 1'b0, 0, 0, 1'b0);
        repeat (20) cyc(S_ERR, rb(), rb(), r6(), rb(), rb());
        do_reset();
        cyc(S_INI, rb(), rb(), r6(), 1'b0, rb());
        cyc(S_BUS, 1'b0, rb(), r6(), rb(), rb());
        do_reset();
        // Fetch timeout.
        cyc(S_INI, rb(), rb(), r6(), 1'b0, rb());
        repeat (4) cyc(S_BUS, 1'b0, rb(), r6(), rb(), rb());
        repeat (3) cyc(S_ERR, rb(), rb(), r6(), rb(), rb());
        // Load timeout.
        do_reset();
        cyc(S_INI, rb(), rb(), r6(), 1'b0, rb());
        cyc(S_BUS, 1'b1, rb(), r6(), rb(), rb());
        cyc(S_DEC, rb(), rb(), T_LW, rb(), rb());
        cyc(S_CAL, rb(), rb(), T_LW, rb(), rb());
        repeat (4) cyc(S_LER, 1'b0, rb(), T_LW, rb(), rb());
        repeat (3) cyc(S_ERR, rb(), rb(), T_LW, rb(), rb());
        // Pause and single-step.
        do_reset();
        cyc(S_INI, rb(), rb(), r6(), 1'b1, rb());
        repeat (3) cyc(S_PAU, rb(), rb(), r6(), 1'b1, 1'b0);
        cyc(S_PAU, rb(), rb(), r6(), 1'b1, 1'b1);
        run_instr(T_ADDI, 1'b0, 0, 0, 1'b1);
        cyc(S_PAU, rb(), rb(), r6(), 1'b1, 1'b0);
        cyc(S_PAU, rb(), rb(), r6(), 1'b0, 1'b0);
        run_instr(T_R, 1'b0, 0, 0, 1'b0);
        run_instr(T_J, 1'b0, 0, 0, 1'b0);
        cyc(S_BUS, 1'b0, rb(), r6(), rb(), rb());
        @(negedge clock);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
